button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_if.sv | 33 +++
 rtl/button_debounce.sv | 135 +++++++++++++
 tb/tb_button_debounce.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Push-button debouncer signal bundle.
// Groups the raw contact input with the debounced level and event pulses so
// the debouncer and its consumer share one connection.
//   button_raw    : asynchronous, bouncy contact, high = pressed
//   button_press  : debounced level, high = pressed
//   press_pulse   : one-cycle pulse on an accepted press
//   release_pulse : one-cycle pulse on an accepted release
//   long_press    : one-cycle pulse once a press has been held long enough
// master = the debouncer itself, slave = whoever drives the raw contact and
// consumes the debounced results.
interface button_debounce_if;
   logic button_raw;
   logic button_press;
   logic press_pulse;
   logic release_pulse;
   logic long_press;

   modport master (
      input  button_raw,
      output button_press,
      output press_pulse,
      output release_pulse,
      output long_press
   );

   modport slave (
      output button_raw,
      input  button_press,
      input  press_pulse,
      input  release_pulse,
      input  long_press
   );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer with press, release and long-press detection.
// The raw contact is synchronized through a SYNC_STAGES flop chain.  A level
// change is accepted only after the synchronized sample has disagreed with
// the current level for DEBOUNCE_CYCLES+1 consecutive samples.  A hold counter
// measures how long an accepted press has lasted and fires long_press once.
// Ports:
//   clk     : single rising-edge clock
//   n_reset : asynchronous active-low reset
//   bus     : button_debounce_if master (raw input, debounced outputs)
module button_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LONG_CYCLES     = 16
) (
   input logic               clk,
   input logic               n_reset,
   button_debounce_if.master bus
);

   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ARMING    = 2'd1;
   localparam logic [1:0] PRESSED   = 2'd2;
   localparam logic [1:0] RELEASING = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   button_press_q, button_press_d;
   logic                   press_pulse_q, press_pulse_d;
   logic                   release_pulse_q, release_pulse_d;
   logic                   long_press_q, long_press_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Next-state logic.  The hold counter restarts only on a fresh press
   // (ARMING->PRESSED), so a bounce that returns from RELEASING to PRESSED
   // keeps counting the same press and long_press stays single-shot.
   always_comb begin
      sync_d          = {sync_q[SYNC_STAGES-2:0], bus.button_raw};
      state_d         = state_q;
      cnt_d           = cnt_q;
      hold_d          = hold_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_press_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (s) begin
               state_d = ARMING;
               cnt_d   = '0;
            end
         end
         ARMING: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d       = PRESSED;
               press_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_d = RELEASING;
               cnt_d   = '0;
            end
         end
         RELEASING: begin
            if (s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d         = IDLE;
               release_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      button_press_d = (state_d == PRESSED) || (state_d == RELEASING);

      // Saturating hold counter; long_press fires on the single cycle the
      // count first reaches LONG_CYCLES.
      if (press_pulse_d) begin
         hold_d = '0;
      end else if (button_press_q && (hold_q != HOLD_MAX)) begin
         hold_d       = hold_q + 1'b1;
         long_press_d = (hold_d == HOLD_MAX);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync_q          <= '0;
         state_q         <= IDLE;
         cnt_q           <= '0;
         hold_q          <= '0;
         button_press_q  <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
      end else begin
         sync_q          <= sync_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         hold_q          <= hold_d;
         button_press_q  <= button_press_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_press_q    <= long_press_d;
      end
   end

   assign bus.button_press  = button_press_q;
   assign bus.press_pulse   = press_pulse_q;
   assign bus.release_pulse = release_pulse_q;
   assign bus.long_press    = long_press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce.
// A behavioural model tracks the debounced level as "how many consecutive
// synchronized samples disagree with the accepted level"; the level flips
// once that run reaches DEBOUNCE_CYCLES+1.  Directed scenarios (short glitch,
// long press, release bounce, mid-press reset, fast toggling) are followed by
// random segments of random level and length.
module tb_button_debounce;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int LONG_CYCLES     = 16;

   logic clk;
   logic n_reset;

   button_debounce_if bus();

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: raw-sample delay line, accepted level, length of
   // the current disagreeing run, press duration and the registered pulses.
   bit dly [SYNC_STAGES];
   bit m_level;
   int m_run;
   int m_held;
   bit m_press;
   bit m_release;
   bit m_long;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < SYNC_STAGES; i++) dly[i] = 1'b0;
      m_level   = 1'b0;
      m_run     = 0;
      m_held    = 0;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_long    = 1'b0;
   endtask

   // Advance the model by one clock edge that samples raw.
   task automatic modelStep(input bit raw);
      bit s;
      bit new_level;
      s = dly[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = raw;

      m_press   = 1'b0;
      m_release = 1'b0;
      m_long    = 1'b0;

      if (s != m_level) m_run++;
      else m_run = 0;

      new_level = m_level;
      if (m_run == DEBOUNCE_CYCLES + 1) begin
         new_level = ~m_level;
         m_run     = 0;
         if (new_level) m_press = 1'b1;
         else m_release = 1'b1;
      end

      if (m_press) begin
         m_held = 0;
      end else if (m_level && m_held < LONG_CYCLES) begin
         m_held++;
         if (m_held == LONG_CYCLES) m_long = 1'b1;
      end

      m_level = new_level;
   endtask

   task automatic compareAll();
      checkOutput("button_press", bus.button_press, m_level);
      checkOutput("press_pulse", bus.press_pulse, m_press);
      checkOutput("release_pulse", bus.release_pulse, m_release);
      checkOutput("long_press", bus.long_press, m_long);
      checkOutput("press_release_excl", bus.press_pulse & bus.release_pulse, 1'b0);
      checkOutput("long_press_excl", bus.long_press & bus.press_pulse, 1'b0);
   endtask

   // Hold raw at a level for a number of cycles, checking every cycle.
   task automatic applyStimulus(input bit raw, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         compareAll();
         bus.button_raw = raw;
         modelStep(raw);
      end
   endtask

   initial begin
      bus.button_raw = 1'b0;
      n_reset        = 1'b0;
      modelReset();

      #12;
      checkOutput("reset_button_press", bus.button_press, 1'b0);
      checkOutput("reset_press_pulse", bus.press_pulse, 1'b0);
      checkOutput("reset_release_pulse", bus.release_pulse, 1'b0);
      checkOutput("reset_long_press", bus.long_press, 1'b0);

      @(negedge clk);
      n_reset = 1'b1;
      modelStep(1'b0);

      // Short glitch of exactly DEBOUNCE_CYCLES samples must be ignored.
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, DEBOUNCE_CYCLES);
      applyStimulus(1'b0, 12);

      // Long press with long_press, then a clean release.
      applyStimulus(1'b1, 30);
      applyStimulus(1'b0, 12);

      // Release bounce of three cycles while pressed.
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 3);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 12);

      // Fast toggling never qualifies.
      for (int i = 0; i < 50; i++) applyStimulus(bit'(i % 2), 1);
      applyStimulus(1'b0, 6);

      // Reset asserted mid-press, away from a clock edge.
      applyStimulus(1'b1, 12);
      @(posedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      checkOutput("async_rst_button_press", bus.button_press, 1'b0);
      checkOutput("async_rst_press_pulse", bus.press_pulse, 1'b0);
      checkOutput("async_rst_release_pulse", bus.release_pulse, 1'b0);
      checkOutput("async_rst_long_press", bus.long_press, 1'b0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("held_rst_release_pulse", bus.release_pulse, 1'b0);
      n_reset = 1'b1;
      modelStep(bus.button_raw);
      applyStimulus(1'b1, 25);
      applyStimulus(1'b0, 12);

      // Random segments: mostly bounce-length runs, sometimes long holds.
      for (int seg = 0; seg < 150; seg++) begin
         bit lvl;
         int len;
         lvl = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) len = $urandom_range(15, 25);
         else len = $urandom_range(1, DEBOUNCE_CYCLES + 2);
         applyStimulus(lvl, len);
      end
      applyStimulus(1'b0, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
